// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle datapath. Walks each instruction
// through fetch/decode/execute/memory/writeback, drives every datapath
// enable and mux select, stalls on the memory-ready handshake, flags
// unsupported opcodes and counts retired instructions.
//
// Handshake: mem_ready is a completion strobe from memory. A memory state
// (FETCH, MEMRD, MEMWR) holds with constant outputs while mem_ready=0, and
// the access completes on the rising edge at which mem_ready=1. No
// back-pressure flows to memory; memread/memwrite simply stay asserted.
module multicycle_control #(
  parameter int CNT_W       = 32,
  parameter int MEM_WAIT_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             memtoreg,
  output logic             regdst,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsource,
  output logic [1:0]       aluop,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t cur_state;
  state_t next_state;
  logic   rdy;
  logic   retire;

  // With waiting disabled, memory is assumed to finish every access at once.
  assign rdy   = (MEM_WAIT_EN == 0) ? 1'b1 : mem_ready;
  assign state = cur_state;

  // State register; reset parks the machine in FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= FETCH;
    else     cur_state <= next_state;
  end

  // Next-state and Moore output decode; everything held at 0 while in reset.
  always_comb begin
    next_state  = cur_state;
    retire      = 1'b0;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsource    = 2'b00;
    aluop       = 2'b00;
    illegal_op  = 1'b0;
    case (cur_state)
      FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = rdy;
        pcwrite = rdy;
        if (rdy) next_state = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXEC;
          OP_BEQ:       next_state = BRANCH;
          OP_J:         next_state = JUMP;
          OP_ADDI:      next_state = ADDIEX;
          default: begin
            illegal_op = 1'b1;
            next_state = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        // Only lw/sw reach here; anything else is abandoned without retiring.
        if (opcode == OP_LW)      next_state = MEMRD;
        else if (opcode == OP_SW) next_state = MEMWR;
        else                      next_state = FETCH;
      end
      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (rdy) next_state = MEMWB;
      end
      MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (rdy) begin
          retire     = 1'b1;
          next_state = FETCH;
        end
      end
      EXEC: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        next_state = RWB;
      end
      RWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        alusrca     = 1'b1;
        aluop       = 2'b10;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
        retire      = 1'b1;
        next_state  = FETCH;
      end
      JUMP: begin
        pcwrite    = 1'b1;
        pcsource   = 2'b10;
        retire     = 1'b1;
        next_state = FETCH;
      end
      ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = ADDIWB;
      end
      ADDIWB: begin
        regwrite   = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase
    if (rst) begin
      retire      = 1'b0;
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      iord        = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      memtoreg    = 1'b0;
      regdst      = 1'b0;
      regwrite    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      pcsource    = 2'b00;
      aluop       = 2'b00;
      illegal_op  = 1'b0;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with a 4-bit retired counter so the
// wrap can be reached quickly. Expected control words are hand-written from
// the per-state output table.
module tb_multicycle_control;

  localparam int CNT_W = 4;

  // Control word packing:
  // [15]pcwrite [14]pcwritecond [13]iord [12]memread [11]memwrite [10]irwrite
  // [9]memtoreg [8]regdst [7]regwrite [6]alusrca [5:4]alusrcb [3:2]pcsource [1:0]aluop
  localparam logic [15:0] C_FETCH_R = 16'h9410;
  localparam logic [15:0] C_FETCH_S = 16'h1010;
  localparam logic [15:0] C_DECODE  = 16'h0030;
  localparam logic [15:0] C_MEMADR  = 16'h0060;
  localparam logic [15:0] C_MEMRD   = 16'h3000;
  localparam logic [15:0] C_MEMWB   = 16'h0280;
  localparam logic [15:0] C_MEMWR   = 16'h2800;
  localparam logic [15:0] C_EXEC    = 16'h0041;
  localparam logic [15:0] C_RWB     = 16'h0180;
  localparam logic [15:0] C_BRANCH  = 16'h4046;
  localparam logic [15:0] C_JUMP    = 16'h8008;
  localparam logic [15:0] C_ADDIEX  = 16'h0060;
  localparam logic [15:0] C_ADDIWB  = 16'h0080;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic             clk, rst, mem_ready;
  logic [5:0]       opcode;
  logic             pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic             memtoreg, regdst, regwrite, alusrca, illegal_op;
  logic [1:0]       alusrcb, pcsource, aluop;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;
  logic [15:0]      ctl;

  int n_assert = 0;
  int n_fail   = 0;

  multicycle_control #(.CNT_W(CNT_W), .MEM_WAIT_EN(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsource(pcsource),
    .aluop(aluop), .illegal_op(illegal_op), .state(state), .retired(retired)
  );

  assign ctl = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource, aluop};

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs for one cycle, check the Moore outputs, then advance past the edge.
  task automatic step(input logic [5:0] op, input logic mr, input logic [3:0] exp_st,
                      input logic [15:0] exp_ctl, input logic exp_ill);
    opcode    = op;
    mem_ready = mr;
    #1;
    chk($sformatf("state@%0t", $time), {28'd0, state}, {28'd0, exp_st});
    chk($sformatf("ctl@%0t", $time), {16'd0, ctl}, {16'd0, exp_ctl});
    chk($sformatf("illegal@%0t", $time), {31'd0, illegal_op}, {31'd0, exp_ill});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ret(input string tag, input logic [CNT_W-1:0] exp);
    chk(tag, {{(32-CNT_W){1'b0}}, retired}, {{(32-CNT_W){1'b0}}, exp});
  endtask

  task automatic run_j();
    step(OP_J, 1'b1, 4'd0, C_FETCH_R, 1'b0);
    step(OP_J, 1'b1, 4'd1, C_DECODE,  1'b0);
    step(OP_J, 1'b1, 4'd9, C_JUMP,    1'b0);
  endtask

  initial begin
    // Reset
    rst = 1'b1; opcode = OP_R; mem_ready = 1'b1;
    #2;
    chk("reset_state", {28'd0, state}, 32'd0);
    chk("reset_ctl", {16'd0, ctl}, 32'd0);
    chk("reset_illegal", {31'd0, illegal_op}, 32'd0);
    chk_ret("reset_retired", 4'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;

    // R-type: 0,1,6,7,0
    step(OP_R, 1'b1, 4'd0, C_FETCH_R, 1'b0);
    step(OP_R, 1'b1, 4'd1, C_DECODE,  1'b0);
    step(OP_R, 1'b1, 4'd6, C_EXEC,    1'b0);
    chk_ret("r_before_retire", 4'd0);
    step(OP_R, 1'b1, 4'd7, C_RWB,     1'b0);
    chk_ret("r_retired", 4'd1);

    // lw with three stall cycles in MEMRD
    step(OP_LW, 1'b1, 4'd0, C_FETCH_R, 1'b0);
    step(OP_LW, 1'b1, 4'd1, C_DECODE,  1'b0);
    step(OP_LW, 1'b1, 4'd2, C_MEMADR,  1'b0);
    for (int i = 0; i < 3; i++) step(OP_LW, 1'b0, 4'd3, C_MEMRD, 1'b0);
    step(OP_LW, 1'b1, 4'd3, C_MEMRD,   1'b0);
    step(OP_LW, 1'b1, 4'd4, C_MEMWB,   1'b0);
    chk_ret("lw_retired", 4'd2);

    // sw with one stall cycle in MEMWR
    step(OP_SW, 1'b1, 4'd0, C_FETCH_R, 1'b0);
    step(OP_SW, 1'b1, 4'd1, C_DECODE,  1'b0);
    step(OP_SW, 1'b1, 4'd2, C_MEMADR,  1'b0);
    step(OP_SW, 1'b0, 4'd5, C_MEMWR,   1'b0);
    chk_ret("sw_stalled", 4'd2);
    step(OP_SW, 1'b1, 4'd5, C_MEMWR,   1'b0);
    chk_ret("sw_retired", 4'd3);

    // beq, j, addi
    step(OP_BEQ, 1'b1, 4'd0, C_FETCH_R, 1'b0);
    step(OP_BEQ, 1'b1, 4'd1, C_DECODE,  1'b0);
    step(OP_BEQ, 1'b1, 4'd8, C_BRANCH,  1'b0);
    chk_ret("beq_retired", 4'd4);
    run_j();
    chk_ret("j_retired", 4'd5);
    step(OP_ADDI, 1'b1, 4'd0,  C_FETCH_R, 1'b0);
    step(OP_ADDI, 1'b1, 4'd1,  C_DECODE,  1'b0);
    step(OP_ADDI, 1'b1, 4'd10, C_ADDIEX,  1'b0);
    step(OP_ADDI, 1'b1, 4'd11, C_ADDIWB,  1'b0);
    chk_ret("addi_retired", 4'd6);

    // Illegal opcode: one-cycle pulse in DECODE, back to FETCH, no retire
    step(OP_BAD, 1'b1, 4'd0, C_FETCH_R, 1'b0);
    step(OP_BAD, 1'b1, 4'd1, C_DECODE,  1'b1);
    chk_ret("illegal_no_retire", 4'd6);

    // FETCH stalled two cycles, then R-type
    step(OP_R, 1'b0, 4'd0, C_FETCH_S, 1'b0);
    step(OP_R, 1'b0, 4'd0, C_FETCH_S, 1'b0);
    step(OP_R, 1'b1, 4'd0, C_FETCH_R, 1'b0);
    step(OP_R, 1'b1, 4'd1, C_DECODE,  1'b0);
    step(OP_R, 1'b1, 4'd6, C_EXEC,    1'b0);
    step(OP_R, 1'b1, 4'd7, C_RWB,     1'b0);
    chk_ret("stall_r_retired", 4'd7);

    // Reset asserted during a lw stall in MEMRD: takes effect without a clock edge
    step(OP_LW, 1'b1, 4'd0, C_FETCH_R, 1'b0);
    step(OP_LW, 1'b1, 4'd1, C_DECODE,  1'b0);
    step(OP_LW, 1'b1, 4'd2, C_MEMADR,  1'b0);
    step(OP_LW, 1'b0, 4'd3, C_MEMRD,   1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_state", {28'd0, state}, 32'd0);
    chk("midrst_ctl", {16'd0, ctl}, 32'd0);
    chk_ret("midrst_retired", 4'd0);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("midrst_hold_ctl", {16'd0, ctl}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    run_j();
    chk_ret("after_rst_j", 4'd1);

    // Counter wrap: 14 more jumps to reach 15, one more wraps to 0
    for (int i = 0; i < 14; i++) run_j();
    chk_ret("retired_max", 4'd15);
    run_j();
    chk_ret("retired_wrap", 4'd0);
    step(OP_J, 1'b1, 4'd0, C_FETCH_R, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle datapath; sits directly upstream of the ALU-control decoder and drives its 2-bit aluop.
- Sequences each instruction through fetch/decode/execute/memory/writeback states from the 6-bit opcode.
- Issues all datapath enables and mux selects.
- Waits on a memory-ready handshake, flags illegal opcodes and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- MEM_WAIT_EN, 1, when 1 memory states wait for mem_ready; when 0 mem_ready is treated as constant 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  6  instr[31:26] from the instruction register.
- mem_ready  input  1  memory completes the current read/write this cycle.
- pcwrite  output  1  unconditional PC load.
- pcwritecond  output  1  PC load qualified by ALU zero (beq).
- iord  output  1  memory address select: 0=PC, 1=ALUOut.
- memread  output  1  memory read request.
- memwrite  output  1  memory write request.
- irwrite  output  1  instruction register load.
- memtoreg  output  1  register write data: 0=ALUOut, 1=MDR.
- regdst  output  1  destination register: 0=rt, 1=rd.
- regwrite  output  1  register file write.
- alusrca  output  1  ALU A operand: 0=PC, 1=A.
- alusrcb  output  2  ALU B operand: 00=B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2.
- pcsource  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- aluop  output  2  00=add, 10=subtract, 01=use funct field.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.
- state  output  4  current state, for debug.
- retired  output  CNT_W  count of completed instructions.

Behaviour:
- Reset (async, rst high):
  - state=FETCH(0), retired=0.
  - All control outputs and illegal_op forced to 0 for as long as rst is high, including mid-instruction.
  - After release, the first clock edge begins the fetch.
- Outputs are Moore, decoded from the registered state. The only exceptions are irwrite/pcwrite in FETCH, which are also qualified by mem_ready.
- Every output not listed for a state is 0. aluop is 00 unless stated.
- Supported opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.
- States, outputs and transitions:
  - FETCH(0): memread=1, iord=0, alusrca=0, alusrcb=01, pcsource=00, irwrite=pcwrite=mem_ready. Holds while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE(1): alusrca=0, alusrcb=11.
    - Next state by opcode: lw/sw->MEMADR, R->EXEC, beq->BRANCH, j->JUMP, addi->ADDIEX.
    - Any other opcode: illegal_op=1 for this cycle, go to FETCH, retired unchanged.
  - MEMADR(2): alusrca=1, alusrcb=10. lw->MEMRD, sw->MEMWR.
  - MEMRD(3): memread=1, iord=1. Holds until mem_ready, then goes to MEMWB.
  - MEMWB(4): regwrite=1, memtoreg=1, regdst=0. Goes to FETCH.
  - MEMWR(5): memwrite=1, iord=1. Holds until mem_ready, then goes to FETCH.
  - EXEC(6): alusrca=1, alusrcb=00, aluop=01. Goes to RWB.
  - RWB(7): regwrite=1, regdst=1, memtoreg=0. Goes to FETCH.
  - BRANCH(8): alusrca=1, alusrcb=00, aluop=10, pcwritecond=1, pcsource=01. Goes to FETCH.
  - JUMP(9): pcwrite=1, pcsource=10. Goes to FETCH.
  - ADDIEX(10): alusrca=1, alusrcb=10. Goes to ADDIWB.
  - ADDIWB(11): regwrite=1, regdst=0, memtoreg=0. Goes to FETCH.
  - Unused codes 12-15: all outputs 0, go to FETCH next cycle.
- Opcode is sampled only in DECODE and MEMADR. The instruction register is stable during these states because irwrite is 0.
- retired increments by 1 on each transition into FETCH from MEMWB, MEMWR, RWB, BRANCH, JUMP or ADDIWB. It wraps modulo 2^CNT_W.
- Cycle counts with mem_ready tied to 1:
  - lw: 5 cycles.
  - sw and R-type: 4 cycles.
  - beq, j and addi: 3, 3 and 4 cycles respectively.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. Outputs stay constant during the stall, apart from the mem_ready-gated enables in FETCH.

Test Plan:
- Reset mid-MEMRD (assert rst during a lw stall) -> state=0 and all outputs 0 immediately without waiting for a clock edge; after release the fetch restarts and retired=0.
- R-type (opcode 000000), mem_ready=1 -> state sequence 0,1,6,7,0; aluop=01 only in state 6; regwrite=1 and regdst=1 in state 7; retired 0->1.
- lw with mem_ready low for 3 cycles in MEMRD -> sequence 0,1,2,3,3,3,3,4,0; memread=1 and iord=1 held throughout state 3; memtoreg=1 in state 4.
- beq -> state 8 drives aluop=10, alusrca=1, alusrcb=00, pcwritecond=1, pcsource=01; j -> state 9 drives pcwrite=1, pcsource=10; retired increments once per instruction.
- Illegal opcode 111111 -> illegal_op high for exactly 1 cycle in DECODE, next state 0, retired unchanged.
- FETCH with mem_ready=0 for 2 cycles -> irwrite=0 and pcwrite=0 for those 2 cycles, both 1 on the ready cycle; retired wraps from 2^CNT_W-1 to 0 (test with CNT_W=4: 15->0).
